// File: rtl/sd_spi_pkg.sv
// Shared SPI host definitions: FSM encoding, idle byte and SD command bytes.
package sd_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOW    = 2'd1,
    ST_HIGH   = 2'd2,
    ST_FINISH = 2'd3
  } spi_state_t;

  localparam logic [7:0] SPI_IDLE_BYTE = 8'hFF;

  localparam logic [7:0] CMD0       = 8'h40;
  localparam logic [7:0] CMD8       = 8'h48;
  localparam logic [7:0] CMD17      = 8'h51;
  localparam logic [7:0] CMD24      = 8'h58;
  localparam logic [7:0] CMD55      = 8'h77;
  localparam logic [7:0] ACMD41     = 8'h69;
  localparam logic [7:0] CMD58      = 8'h7A;
  localparam logic [7:0] DATA_TOKEN = 8'hFE;
  localparam logic [7:0] WRITE_RESP = 8'h05;

  // Divider width: one bit more than needed for the larger half-period.
  function automatic int div_width(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/sd_spi_master_if.sv
// Core-side byte interface of the SD SPI host.
//
// Handshake: there is no backpressure. tx_start is a one-cycle request that is
// accepted only while the host is idle (busy=0, state IDLE); requests at any
// other time are dropped. cs_wr follows the same acceptance rule. done is a
// one-cycle completion pulse, and rx_data holds the received byte from the
// done cycle until the next done. state mirrors the host FSM for observation.
interface sd_spi_master_if;
  import sd_spi_pkg::*;

  logic [7:0] tx_data;
  logic       tx_start;
  logic       cs_wr;
  logic       cs_val;
  logic       fast;
  logic [7:0] rx_data;
  logic       busy;
  logic       done;
  spi_state_t state;

  modport master (
    output tx_data, tx_start, cs_wr, cs_val, fast,
    input  rx_data, busy, done, state
  );

  modport slave (
    input  tx_data, tx_start, cs_wr, cs_val, fast,
    output rx_data, busy, done, state
  );

endinterface

// File: rtl/sd_spi_clkdiv.sv
// Loadable half-period counter; tick marks the last clk cycle of a sck phase.
module sd_spi_clkdiv #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] half,
  output logic         tick
);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == half - W'(1));

  // Count up within a phase and hold at the terminal count; restart on clear.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (en && !tick) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/sd_spi_master.sv
// SPI mode 0 byte host for the SD card emulation, MSB first.
module sd_spi_master
  import sd_spi_pkg::*;
#(
  parameter int DIV_SLOW = 27,
  parameter int DIV_FAST = 2
) (
  input  logic            clk,
  input  logic            reset,
  sd_spi_master_if.slave  bus,
  output logic            sd_cs,
  output logic            sd_sck,
  output logic            sd_sdi,
  input  logic            sd_sdo
);

  localparam int DW = div_width(DIV_SLOW, DIV_FAST);

  spi_state_t    state_q;
  spi_state_t    state_d;
  logic [7:0]    shreg;
  logic [7:0]    rx_q;
  logic [2:0]    bit_cnt;
  logic [DW-1:0] half_q;
  logic          tick;
  logic          div_clear;
  logic          div_en;

  // The divider restarts on every state entry and stays cleared while idle.
  assign div_clear = (state_d != state_q) || (state_q == ST_IDLE);
  assign div_en    = (state_q == ST_LOW) || (state_q == ST_HIGH);

  sd_spi_clkdiv #(.W(DW)) u_clkdiv (
    .clk   (clk),
    .reset (reset),
    .clear (div_clear),
    .en    (div_en),
    .half  (half_q),
    .tick  (tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: two half-periods per bit, one FINISH cycle per byte.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (bus.tx_start) state_d = ST_LOW;
      ST_LOW:    if (tick) state_d = ST_HIGH;
      ST_HIGH:   if (tick) state_d = (bit_cnt == 3'd7) ? ST_FINISH : ST_LOW;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    bus.busy    = (state_q == ST_LOW) || (state_q == ST_HIGH);
    bus.done    = (state_q == ST_FINISH);
    bus.rx_data = rx_q;
    bus.state   = state_q;
  end

  // Datapath: chip select, sck/MOSI generation, MISO capture.
  // MOSI only moves at the falling-edge cycle, so it is stable for a whole
  // low phase before each rising edge; MISO is captured as sck rises.
  always_ff @(posedge clk) begin
    if (reset) begin
      sd_cs   <= 1'b1;
      sd_sck  <= 1'b0;
      sd_sdi  <= 1'b1;
      shreg   <= SPI_IDLE_BYTE;
      rx_q    <= SPI_IDLE_BYTE;
      bit_cnt <= 3'd0;
      half_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.cs_wr) sd_cs <= bus.cs_val;
          if (bus.tx_start) begin
            shreg   <= bus.tx_data;
            sd_sdi  <= bus.tx_data[7];
            half_q  <= bus.fast ? DW'(DIV_FAST) : DW'(DIV_SLOW);
            bit_cnt <= 3'd0;
          end
        end
        ST_LOW: begin
          if (tick) begin
            sd_sck <= 1'b1;
            shreg  <= {shreg[6:0], sd_sdo};
          end
        end
        ST_HIGH: begin
          if (tick) begin
            sd_sck <= 1'b0;
            if (bit_cnt == 3'd7) begin
              // Publish now so rx_data is already valid in the done cycle.
              rx_q <= shreg;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              sd_sdi  <= shreg[7];
            end
          end
        end
        ST_FINISH: begin
          sd_sdi <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_spi_master.sv
// Bench for sd_spi_master: vector table, a small SD card model, corner cases.
module tb_sd_spi_master;
  import sd_spi_pkg::*;

  localparam int H_SLOW = 27;
  localparam int H_FAST = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sd_spi_master_if bus();
  logic sd_cs, sd_sck, sd_sdi, sd_sdo, card_sdo;
  bit   loopback;

  assign sd_sdo = loopback ? sd_sdi : card_sdo;

  sd_spi_master #(.DIV_SLOW(H_SLOW), .DIV_FAST(H_FAST)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus.slave),
    .sd_cs  (sd_cs),
    .sd_sck (sd_sck),
    .sd_sdi (sd_sdi),
    .sd_sdo (sd_sdo)
  );

  // ---------------- SD card model ----------------
  // Samples sdi on rising sck, shifts sdo on falling sck, answers commands
  // after four 0xFF bytes. Deselect resets it.
  logic [7:0] card_in;
  logic [7:0] card_out;
  logic [7:0] card_next;
  logic [7:0] card_cmd [6];
  logic [7:0] resp_q [$];
  int         card_bits;
  int         card_cmd_cnt;

  always @(posedge sd_sck or posedge sd_cs) begin
    if (sd_cs) begin
      card_bits    = 0;
      card_cmd_cnt = 0;
      resp_q.delete();
      card_next    = SPI_IDLE_BYTE;
    end else begin
      card_in = {card_in[6:0], sd_sdi};
      card_bits++;
      if (card_bits == 8) begin
        card_bits = 0;
        if (card_cmd_cnt == 0) begin
          if (card_in[7:6] == 2'b01) begin
            card_cmd[0]  = card_in;
            card_cmd_cnt = 1;
          end
        end else begin
          card_cmd[card_cmd_cnt] = card_in;
          card_cmd_cnt++;
          if (card_cmd_cnt == 6) begin
            card_cmd_cnt = 0;
            repeat (4) resp_q.push_back(SPI_IDLE_BYTE);
            case (card_cmd[0])
              CMD0:  resp_q.push_back(8'h01);
              CMD58: begin
                resp_q.push_back(8'h00);
                resp_q.push_back(8'h40);
                resp_q.push_back(8'h00);
                resp_q.push_back(8'h00);
                resp_q.push_back(8'h00);
              end
              default: resp_q.push_back(8'h04);
            endcase
          end
        end
        card_next = (resp_q.size() > 0) ? resp_q.pop_front() : SPI_IDLE_BYTE;
      end
    end
  end

  always @(negedge sd_sck or posedge sd_cs) begin
    if (sd_cs) card_out = SPI_IDLE_BYTE;
    else if (card_bits == 0) card_out = card_next;
    else card_out = {card_out[6:0], 1'b1};
  end

  assign card_sdo = card_out[7];

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] got);
    logic [31:0] exp;
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  // ---------------- driver ----------------
  // One byte transfer, monitored every cycle at the falling clk edge.
  // n counts cycles after the tx_start cycle.
  task automatic do_xfer(input logic [7:0] tx, input logic f, input int inject_at,
                         input bit cs_with_start,
                         output logic [7:0] rx, output int lat, output int busy_cnt,
                         output int done_cnt, output int rises, output logic [7:0] bits,
                         output bit phase_ok, output bit cs_held);
    int   last_edge, last_sdi_chg, h;
    logic prev_sck, prev_sdi, cs0;
    h = f ? H_FAST : H_SLOW;
    @(negedge clk);
    bus.tx_data  = tx;
    bus.fast     = f;
    bus.tx_start = 1'b1;
    if (cs_with_start) begin
      bus.cs_wr  = 1'b1;
      bus.cs_val = 1'b0;
    end
    cs0 = cs_with_start ? 1'b0 : sd_cs;
    prev_sck = sd_sck;
    prev_sdi = sd_sdi;
    lat = -1; busy_cnt = 0; done_cnt = 0; rises = 0; bits = 8'h00;
    phase_ok = 1'b1; cs_held = 1'b1; last_edge = 0; last_sdi_chg = 0; rx = 8'h00;
    for (int n = 1; n <= 1000; n++) begin
      @(negedge clk);
      bus.tx_start = 1'b0;
      bus.cs_wr    = 1'b0;
      bus.cs_val   = 1'b0;
      if (sd_cs !== cs0) cs_held = 1'b0;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (lat < 0) begin
          lat = n;
          rx  = bus.rx_data;
        end
      end
      if (sd_sdi !== prev_sdi) last_sdi_chg = n;
      if (sd_sck !== prev_sck) begin
        if (last_edge > 0 && (n - last_edge) != h) phase_ok = 1'b0;
        if (sd_sck) begin
          rises++;
          bits = {bits[6:0], sd_sdi};
          if ((n - last_sdi_chg) < h) phase_ok = 1'b0;
        end
        last_edge = n;
      end
      prev_sck = sd_sck;
      prev_sdi = sd_sdi;
      if (n == inject_at) begin
        bus.tx_start = 1'b1;
        bus.tx_data  = ~tx;
        bus.cs_wr    = 1'b1;
        bus.cs_val   = 1'b1;
        bus.fast     = ~f;
      end
      if (lat > 0 && n >= lat + 3) break;
    end
    if (lat < 0) begin
      $display("FAIL xfer_timeout: got no done expected done within 1000 cycles");
      bad++;
      total++;
      lat = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] tx, output logic [7:0] rx);
    int l, b, d, r;
    logic [7:0] bt;
    bit p, c;
    do_xfer(tx, 1'b1, 0, 1'b0, rx, l, b, d, r, bt, p, c);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] tx;
    logic       f;
    bit         lb;
    logic [7:0] exp_rx;
    int         exp_lat;
    int         exp_busy;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [7:0] rx, bits;
    int   lat, busy_cnt, done_cnt, rises, polls, seen_done;
    bit   phase_ok, cs_held;

    vecs[0] = '{8'h40, 1'b0, 1'b0, 8'hFF, 433, 432};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 8'hA5,  33,  32};
    vecs[2] = '{8'h3C, 1'b1, 1'b1, 8'h3C,  33,  32};
    vecs[3] = '{8'h00, 1'b1, 1'b1, 8'h00,  33,  32};
    vecs[4] = '{8'hC3, 1'b0, 1'b1, 8'hC3, 433, 432};

    bus.tx_data = 8'h00; bus.tx_start = 1'b0; bus.cs_wr = 1'b0;
    bus.cs_val = 1'b0; bus.fast = 1'b0; loopback = 1'b0;

    // Reset values.
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    expect_val(1); check("reset_cs", sd_cs);
    expect_val(0); check("reset_sck", sd_sck);
    expect_val(1); check("reset_sdi", sd_sdi);
    expect_val(0); check("reset_busy", bus.busy);
    expect_val(0); check("reset_done", bus.done);
    expect_val(8'hFF); check("reset_rx", bus.rx_data);

    // Table: timing, bit order, phase lengths, loopback data.
    for (int i = 0; i < 5; i++) begin
      loopback = vecs[i].lb;
      do_xfer(vecs[i].tx, vecs[i].f, 0, 1'b0, rx, lat, busy_cnt, done_cnt, rises,
              bits, phase_ok, cs_held);
      expect_val(vecs[i].exp_lat);  check($sformatf("v%0d_latency", i), lat);
      expect_val(vecs[i].exp_busy); check($sformatf("v%0d_busy_len", i), busy_cnt);
      expect_val(1);                check($sformatf("v%0d_done_pulses", i), done_cnt);
      expect_val(8);                check($sformatf("v%0d_sck_rises", i), rises);
      expect_val(vecs[i].tx);       check($sformatf("v%0d_mosi_bits", i), bits);
      expect_val(1);                check($sformatf("v%0d_phase_timing", i), phase_ok);
      expect_val(vecs[i].exp_rx);   check($sformatf("v%0d_rx", i), rx);
    end

    // Card link: select, CMD0, poll for R1.
    loopback = 1'b0;
    @(negedge clk);
    bus.cs_wr = 1'b1; bus.cs_val = 1'b0;
    @(negedge clk);
    bus.cs_wr = 1'b0;
    expect_val(0); check("cs_select", sd_cs);
    send_byte(CMD0, rx); send_byte(8'h00, rx); send_byte(8'h00, rx);
    send_byte(8'h00, rx); send_byte(8'h00, rx); send_byte(8'h95, rx);
    polls = 0;
    for (int i = 1; i <= 8; i++) begin
      send_byte(SPI_IDLE_BYTE, rx);
      polls = i;
      if (rx != SPI_IDLE_BYTE) break;
    end
    expect_val(5);     check("cmd0_poll_index", polls);
    expect_val(8'h01); check("cmd0_r1", rx);

    // CMD58: R1 then OCR.
    send_byte(CMD58, rx); send_byte(8'h00, rx); send_byte(8'h00, rx);
    send_byte(8'h00, rx); send_byte(8'h00, rx); send_byte(8'hFD, rx);
    for (int i = 1; i <= 8; i++) begin
      send_byte(SPI_IDLE_BYTE, rx);
      if (rx != SPI_IDLE_BYTE) break;
    end
    expect_val(8'h00); check("cmd58_r1", rx);
    send_byte(SPI_IDLE_BYTE, rx); expect_val(8'h40); check("cmd58_ocr0", rx);
    send_byte(SPI_IDLE_BYTE, rx); expect_val(8'h00); check("cmd58_ocr1", rx);
    send_byte(SPI_IDLE_BYTE, rx); expect_val(8'h00); check("cmd58_ocr2", rx);
    send_byte(SPI_IDLE_BYTE, rx); expect_val(8'h00); check("cmd58_ocr3", rx);

    // Ignored mid-byte tx_start / cs_wr / fast change.
    loopback = 1'b1;
    do_xfer(8'h5A, 1'b1, 12, 1'b0, rx, lat, busy_cnt, done_cnt, rises, bits,
            phase_ok, cs_held);
    expect_val(8'h5A); check("ignore_rx", rx);
    expect_val(33);    check("ignore_latency", lat);
    expect_val(32);    check("ignore_busy_len", busy_cnt);
    expect_val(1);     check("ignore_done_pulses", done_cnt);
    expect_val(1);     check("ignore_cs_held", cs_held);
    expect_val(1);     check("ignore_phase_timing", phase_ok);

    // Reset in the middle of bit 4.
    loopback = 1'b0;
    @(negedge clk);
    bus.tx_data = 8'h00; bus.fast = 1'b1; bus.tx_start = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      @(negedge clk);
      bus.tx_start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    expect_val(1);     check("abort_cs", sd_cs);
    expect_val(0);     check("abort_sck", sd_sck);
    expect_val(1);     check("abort_sdi", sd_sdi);
    expect_val(0);     check("abort_busy", bus.busy);
    expect_val(8'hFF); check("abort_rx", bus.rx_data);
    seen_done = 0;
    for (int n = 0; n < 40; n++) begin
      if (bus.done) seen_done++;
      @(negedge clk);
    end
    expect_val(0); check("abort_no_done", seen_done);

    // Select and start in the same cycle after the abort.
    do_xfer(SPI_IDLE_BYTE, 1'b1, 0, 1'b1, rx, lat, busy_cnt, done_cnt, rises, bits,
            phase_ok, cs_held);
    expect_val(1);     check("resume_cs_low", cs_held);
    expect_val(33);    check("resume_latency", lat);
    expect_val(1);     check("resume_done_pulses", done_cnt);
    expect_val(8'hFF); check("resume_rx", rx);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
